// File: rtl/ir_sender.sv
// Instruction byte sender: buffers up to two 16-bit instructions and streams each as hi byte then lo byte.
// Latency: word accepted at edge E shows its high byte from E+1 and its low byte from E+2.
// Backpressure: in_ready drops while both buffer slots hold words; hold only delays the start of a transfer.
module ir_sender (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_opcode,
    input  logic [12:0] in_addr,
    input  logic        hold,
    output logic [7:0]  data,
    output logic        load_ir,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] buf_q [2];
    logic [15:0] buf_d [2];
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic [7:0]  data_q;
    logic [7:0]  lo_byte_q;
    logic        load_ir_q;

    logic        push;
    logic        pop;
    logic [15:0] in_word;

    assign in_word  = {in_opcode, in_addr};
    assign in_ready = (count_q != 2'd2);
    assign push     = in_valid && in_ready;
    // A new transfer may start from IDLE or straight out of LO; never from HI.
    assign pop      = (state_q != HI) && (count_q != 2'd0) && !hold;

    // buf_q[0] is always the head word.
    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                buf_d[count_q[0]] = in_word;
                count_d           = count_q + 2'd1;
            end
            2'b01: begin
                buf_d[0] = buf_q[1];
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with one word resident: the new word replaces the departing head.
                buf_d[0] = in_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            buf_q[0] <= 16'h0000;
            buf_q[1] <= 16'h0000;
        end else begin
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= 8'h00;
            lo_byte_q <= 8'h00;
            load_ir_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, LO: begin
                    if (pop) begin
                        state_q   <= HI;
                        data_q    <= buf_q[0][15:8];
                        lo_byte_q <= buf_q[0][7:0];
                        load_ir_q <= 1'b1;
                    end else begin
                        state_q   <= IDLE;
                        data_q    <= 8'h00;
                        load_ir_q <= 1'b0;
                    end
                end
                HI: begin
                    // The low byte always follows immediately, regardless of hold.
                    state_q   <= LO;
                    data_q    <= lo_byte_q;
                    load_ir_q <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    data_q    <= 8'h00;
                    load_ir_q <= 1'b0;
                end
            endcase
        end
    end

    assign data    = data_q;
    assign load_ir = load_ir_q;
    assign busy    = (state_q != IDLE) || (count_q != 2'd0);

endmodule

// File: tb/tb_ir_sender.sv
// Testbench for ir_sender: scoreboard of expected bus bytes plus per-scenario timing checks.
module tb_ir_sender;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_opcode;
    logic [12:0] in_addr;
    logic        hold;
    logic [7:0]  data;
    logic        load_ir;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    ir_sender dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_addr   (in_addr),
        .hold      (hold),
        .data      (data),
        .load_ir   (load_ir),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [12:0] addr);
        in_valid  = 1'b1;
        in_opcode = op;
        in_addr   = addr;
    endtask

    // Scoreboard: each accepted word queues {opcode, addr[12:8]} then addr[7:0].
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (load_ir === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_byte: got data=%h with load_ir=1, expected no byte", data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        errors++;
                        $display("FAIL sb_byte: got data=%h, expected %h", data, e);
                    end
                end
            end else if (load_ir !== 1'b0 || data !== 8'h00) begin
                errors++;
                $display("FAIL sb_idle_bus: got load_ir=%b data=%h, expected 0/00", load_ir, data);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_opcode, in_addr[12:8]});
                exp_q.push_back(in_addr[7:0]);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0; in_opcode = '0; in_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (load_ir !== 1'b0 || data !== 8'h00 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got load_ir=%b data=%h in_ready=%b busy=%b, expected 0/00/1/0",
                     load_ir, data, in_ready, busy);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        step();
        drive(3'b101, 13'h1A5C);
        step();                    // accepted here
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (load_ir !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_wait: got load_ir=%b busy=%b, expected 0/1", load_ir, busy);
        end
        step();
        @(negedge clk);
        checks++;
        if (load_ir !== 1'b1 || data !== 8'hBA) begin
            errors++;
            $display("FAIL single_hi: got load_ir=%b data=%h, expected 1/BA", load_ir, data);
        end
        step();
        @(negedge clk);
        checks++;
        if (load_ir !== 1'b1 || data !== 8'h5C) begin
            errors++;
            $display("FAIL single_lo: got load_ir=%b data=%h, expected 1/5C", load_ir, data);
        end
        step();
        @(negedge clk);
        checks++;
        if (load_ir !== 1'b0 || data !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: got load_ir=%b data=%h busy=%b, expected 0/00/0", load_ir, data, busy);
        end
    endtask

    task automatic test_back_to_back();
        int run;
        step();
        drive(3'b001, 13'h0001);
        step();
        drive(3'b010, 13'h1F00);
        step();                    // first word enters HI, second word accepted
        drive(3'b111, 13'h00FF);
        @(negedge clk);
        run = (load_ir === 1'b1) ? 1 : 0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_one: got in_ready=%b, expected 1", in_ready);
        end
        step();                    // third word accepted, buffer full
        in_valid = 1'b0;
        @(negedge clk);
        if (load_ir === 1'b1) run++;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_full: got in_ready=%b, expected 0", in_ready);
        end
        step();
        @(negedge clk);
        if (load_ir === 1'b1) run++;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_after_pop: got in_ready=%b, expected 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            if (load_ir === 1'b1) run++;
        end
        checks++;
        if (run != 6) begin
            errors++;
            $display("FAIL b2b_load_run: got %0d consecutive load_ir cycles, expected 6", run);
        end
        step();
        @(negedge clk);
        checks++;
        if (load_ir !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_end: got load_ir=%b busy=%b pending=%0d, expected 0/0/0", load_ir, busy, exp_q.size());
        end
    endtask

    task automatic test_hold();
        hold = 1'b1;
        step();
        drive(3'b011, 13'h0ABC);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (load_ir !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_wait%0d: got load_ir=%b busy=%b, expected 0/1", i, load_ir, busy);
            end
            step();
        end
        hold = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (load_ir !== 1'b1 || data !== 8'h6A) begin
            errors++;
            $display("FAIL hold_release_hi: got load_ir=%b data=%h, expected 1/6A", load_ir, data);
        end
        repeat (2) step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_end: got busy=%b pending=%0d, expected 0/0", busy, exp_q.size());
        end
    endtask

    task automatic test_hold_in_hi();
        step();
        drive(3'b110, 13'h1234);
        step();
        drive(3'b100, 13'h0F0F);
        step();                    // first word in HI, second buffered
        in_valid = 1'b0;
        hold     = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (load_ir !== 1'b1 || data !== 8'h34) begin
            errors++;
            $display("FAIL holdhi_lo: got load_ir=%b data=%h, expected 1/34", load_ir, data);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (load_ir !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL holdhi_wait%0d: got load_ir=%b busy=%b, expected 0/1", i, load_ir, busy);
            end
        end
        step();
        hold = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (load_ir !== 1'b1 || data !== 8'h8F) begin
            errors++;
            $display("FAIL holdhi_second_hi: got load_ir=%b data=%h, expected 1/8F", load_ir, data);
        end
        repeat (2) step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL holdhi_end: got busy=%b pending=%0d, expected 0/0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        step();
        drive(3'b001, 13'h1111);
        step();
        drive(3'b010, 13'h0222);
        step();                    // HI with one word buffered
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (load_ir !== 1'b0 || data !== 8'h00 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got load_ir=%b data=%h in_ready=%b busy=%b, expected 0/00/1/0",
                     load_ir, data, in_ready, busy);
        end
        exp_q.delete();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (load_ir !== 1'b0 || data !== 8'h00 || in_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_after%0d: got load_ir=%b data=%h in_ready=%b busy=%b, expected 0/00/1/0",
                         i, load_ir, data, in_ready, busy);
            end
            step();
        end
    endtask

    task automatic test_full_stall();
        hold = 1'b1;
        step();
        drive(3'b011, 13'h1001);
        step();
        drive(3'b101, 13'h0002);
        step();                    // buffer now full
        drive(3'b111, 13'h1FFF);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_ready: got in_ready=%b busy=%b, expected 0/1", in_ready, busy);
        end
        step();
        hold = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_cycle_ready: got in_ready=%b, expected 0", in_ready);
        end
        step();                    // pop edge: the offered word must not be taken here
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || load_ir !== 1'b1) begin
            errors++;
            $display("FAIL full_after_pop: got in_ready=%b load_ir=%b, expected 1/1", in_ready, load_ir);
        end
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && busy; i++) step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drain: got busy=%b pending=%0d, expected 0/0", busy, exp_q.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step();
            in_valid  = ($urandom_range(0, 2) != 0);
            hold      = ($urandom_range(0, 3) == 0);
            in_opcode = 3'($urandom_range(0, 7));
            in_addr   = 13'($urandom_range(0, 8191));
        end
        step();
        in_valid = 1'b0;
        hold     = 1'b0;
        for (int i = 0; i < 40 && busy; i++) step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got busy=%b pending=%0d, expected 0/0", busy, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_hold_in_hi();
        test_reset_mid();
        test_full_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
